sys_arr_result_drain: RTL and testbench
=======================================

# sys_arr_result_drain

Downstream stage of the systolic array. Captures the M×K single-precision accumulator outputs when the array signals completion and serialises them onto a valid/ready stream, one result per accepted beat, in row-major order. It decouples the array's parallel result bus from the narrow consumer, such as a result FIFO or an AXI-Stream bridge, and reports array errors and drain overruns.

## Interface
Parameters:
- M, 2, number of array rows
- K, 2, number of array columns
- DW, 32, result width (single_float)

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- res_in  in  M*K*DW  flattened array results; element i = r*K+c occupies bits [i*DW +: DW]
- comp_done  in  1  AND of all PE comp_done flags
- error  in  1  array error flag
- out_dat  out  DW  current result
- out_valid  out  1  out_dat valid
- out_ready  in  1  consumer accepts the beat when out_valid is also high
- out_idx  out  $clog2(M*K) (min 1)  row-major index of out_dat
- out_last  out  1  high with the final element (idx M*K-1)
- busy  out  1  high in CAPTURE/DRAIN
- drain_done  out  1  one-cycle pulse after the last beat is accepted
- err_flag  out  1  error sampled at capture; held until the next capture
- overrun  out  1  sticky; comp_done rose while not IDLE; cleared only by reset
- nan_flag  out  1  only with SYS_ARR_DRAIN_NAN_CHECK_EN, else tied 0

## Operation
- comp_done is registered into comp_done_q (reset 0). rise = comp_done & ~comp_done_q.
- FSM states:
  - IDLE: on rise, copy all of res_in into the capture buffer, sample error into err_flag, and clear idx to 0. Go to DRAIN.
  - DRAIN: out_valid=1, out_dat=buf[idx], out_last=(idx==M*K-1).
    - On out_valid&out_ready with idx<M*K-1: idx++.
    - On out_valid&out_ready with idx==M*K-1: go to DONE.
  - DONE: drain_done=1 for exactly one cycle, out_valid=0, then go to IDLE.
- busy = (state==DRAIN). CAPTURE is folded into the IDLE→DRAIN transition edge; no separate cycle.
- A rise in DRAIN or DONE is ignored for capture and sets overrun. The buffer is never overwritten mid-drain.
- out_dat, out_idx and out_last must hold stable while out_valid=1 and out_ready=0. Data is never dropped or duplicated.
- If comp_done stays high after the drain, no re-capture occurs until it falls and rises again.
- Buffer contents are not changed by the drain; only idx advances.

## Timing
- Reset values: out_dat=0, out_valid=0, out_idx=0, out_last=0, busy=0, drain_done=0, err_flag=0, overrun=0, nan_flag=0, state=IDLE, buffer=0.
- Rise seen at posedge T: out_valid=1 with element 0 from T+1.
- With out_ready held high, the last beat is at T+M*K. drain_done pulses at T+M*K+1, and IDLE is entered at T+M*K+2. A rise at T+M*K+2 is captured.
- Each cycle with out_ready=0 adds one cycle to the drain.
- If comp_done is already high when nrst deasserts, it is treated as a rise at the first clock edge.
- Reset asserted mid-drain aborts immediately. All outputs return to their reset values asynchronously, and the partial stream is discarded.
- No combinational path from out_ready to out_valid or out_dat. All outputs are registered or decoded from state/idx/buffer only.

## Configuration
- SYS_ARR_DRAIN_NAN_CHECK_EN defined: at capture, nan_flag is set to 1 if any captured element has exponent 8'hFF and mantissa ≠ 0. It is held until the next capture.
- Undefined: no checker logic is present and nan_flag is constant 0.

## Test plan
- Basic drain: reset, res_in={4.0,5.0,2.0,3.0} (IEEE hex, idx0..3 = 3.0,2.0,5.0,4.0), pulse comp_done, out_ready=1 → beats at T+1..T+4 carrying 0x40400000, 0x40000000, 0x40A00000, 0x40800000 with idx 0..3. out_last only on idx 3. drain_done at T+5.
- Backpressure: same data, out_ready toggling 1,0,0,1,… → every element emitted exactly once, in order. out_dat and idx stay stable during the stall cycles.
- Overrun: raise comp_done again during beat 2 → stream unchanged, overrun=1 and sticky after drain_done.
- Held comp_done: comp_done stays high across the whole drain → exactly one drain, and no second capture until a 1→0→1 transition.
- Reset mid-drain: assert nrst at beat 1 → out_valid=0 immediately. After release with comp_done=0, the block stays IDLE.
- Error/NaN: error=1 at capture with one element 0x7FC00000 → err_flag=1. nan_flag=1 with the macro defined, 0 without it. Both clear on a later clean capture.

Source files
------------

// File: rtl/sys_arr_result_drain.sv
// Result drain for the systolic array: captures the M*K accumulator outputs
// on a comp_done rising edge and serialises them row-major onto a
// valid/ready stream. Also reports array error, capture overrun and
// (optionally) NaN presence.
// Optional feature macro: SYS_ARR_DRAIN_NAN_CHECK_EN (enables nan_flag).
module sys_arr_result_drain #(
   parameter int unsigned M  = 2,
   parameter int unsigned K  = 2,
   parameter int unsigned DW = 32
) (
   input  logic                                    clk,
   input  logic                                    nrst,
   input  logic [M*K*DW-1:0]                       res_in,
   input  logic                                    comp_done,
   input  logic                                    error,
   output logic [DW-1:0]                           out_dat,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [((M*K > 1) ? $clog2(M*K) : 1)-1:0] out_idx,
   output logic                                    out_last,
   output logic                                    busy,
   output logic                                    drain_done,
   output logic                                    err_flag,
   output logic                                    overrun,
   output logic                                    nan_flag
);

   localparam int unsigned N  = M * K;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_d;
   logic            comp_done_q;
   logic            rise_c;
   logic            cap_c;
   logic [IW-1:0]   idx_d;
   logic [DW-1:0]   dat_d;
   logic [DW-1:0]   buf_q [N];

   assign rise_c = comp_done & ~comp_done_q;

   // State register and comp_done edge-detect history
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         comp_done_q <= 1'b0;
      end else begin
         state       <= state_d;
         comp_done_q <= comp_done;
      end
   end

   // Next state, next index and next output data
   always_comb begin
      state_d = state;
      idx_d   = out_idx;
      cap_c   = 1'b0;
      unique case (state)
         IDLE: begin
            if (rise_c) begin
               cap_c   = 1'b1;
               idx_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (out_idx == LAST) state_d = DONE;
               else                 idx_d   = out_idx + IW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // On capture the buffer is not yet loaded, so element 0 comes from res_in
      dat_d = cap_c ? res_in[DW-1:0] : buf_q[idx_d];
   end

   // Registered stream outputs and status flags
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         out_dat    <= '0;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         drain_done <= 1'b0;
         err_flag   <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         out_dat    <= dat_d;
         out_valid  <= (state_d == DRAIN);
         out_idx    <= idx_d;
         out_last   <= (state_d == DRAIN) && (idx_d == LAST);
         busy       <= (state_d == DRAIN);
         drain_done <= (state_d == DONE);
         if (cap_c) err_flag <= error;
         if (rise_c && (state != IDLE)) overrun <= 1'b1;
      end
   end

   // Capture buffer, loaded only on an accepted rise in IDLE
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < int'(N); i++) buf_q[i] <= '0;
      end else if (cap_c) begin
         for (int i = 0; i < int'(N); i++) buf_q[i] <= res_in[i*DW +: DW];
      end
   end

`ifdef SYS_ARR_DRAIN_NAN_CHECK_EN
   logic nan_any_c;

   // NaN = all-ones exponent with a non-zero mantissa
   always_comb begin
      nan_any_c = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if ((res_in[i*DW + DW - 2 -: 8] == 8'hFF) && (res_in[i*DW +: DW - 9] != '0))
            nan_any_c = 1'b1;
      end
   end

   // NaN flag sampled at capture, held until the next capture
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)      nan_flag <= 1'b0;
      else if (cap_c) nan_flag <= nan_any_c;
   end
`else
   assign nan_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sys_arr_result_drain.sv
// Scoreboard bench for sys_arr_result_drain (M=2, K=2, DW=32).
module tb_sys_arr_result_drain;

   localparam int unsigned M  = 2;
   localparam int unsigned K  = 2;
   localparam int unsigned DW = 32;
   localparam int unsigned N  = M * K;
   localparam int unsigned IW = 2;

   typedef struct packed {
      logic [DW-1:0] dat;
      logic [IW-1:0] idx;
      logic          last;
   } beat_t;

   logic              clk;
   logic              nrst;
   logic [N*DW-1:0]   res_in;
   logic              comp_done;
   logic              error;
   logic [DW-1:0]     out_dat;
   logic              out_valid;
   logic              out_ready;
   logic [IW-1:0]     out_idx;
   logic              out_last;
   logic              busy;
   logic              drain_done;
   logic              err_flag;
   logic              overrun;
   logic              nan_flag;

   int                n_chk;
   int                n_fail;
   beat_t             sb[$];
   int                ready_mode;
   logic              exp_nan;

   sys_arr_result_drain #(.M(M), .K(K), .DW(DW)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .res_in     (res_in),
      .comp_done  (comp_done),
      .error      (error),
      .out_dat    (out_dat),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_last   (out_last),
      .busy       (busy),
      .drain_done (drain_done),
      .err_flag   (err_flag),
      .overrun    (overrun),
      .nan_flag   (nan_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load res_in and queue the expected row-major stream
   task automatic load(input logic [N*DW-1:0] d);
      beat_t b;
      res_in = d;
      for (int i = 0; i < int'(N); i++) begin
         b.dat  = d[i*DW +: DW];
         b.idx  = IW'(i);
         b.last = (i == int'(N) - 1);
         sb.push_back(b);
      end
   endtask

   // Wait for the drain_done pulse (bounded), return negedges waited
   task automatic wait_done(input int bound, output int n);
      n = 0;
      @(negedge clk);
      while (!drain_done && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("drain_done_seen", {31'd0, drain_done}, 32'd1);
   endtask

   // out_ready driver: mode 0 always high, mode 1 repeats 1,0,0,1
   initial begin
      int cnt;
      cnt = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) out_ready = 1'b1;
         else out_ready = (cnt % 4 == 0) || (cnt % 4 == 3);
         cnt++;
      end
   end

   // Output monitor: scoreboard pop on accept, stability during stalls
   initial begin
      beat_t  e;
      logic   pv, pr, pl;
      logic [DW-1:0] pd;
      logic [IW-1:0] pi;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pi = '0;
      forever begin
         @(negedge clk);
         if (!nrst) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) begin
               check("stall_valid", {31'd0, out_valid}, 32'd1);
               check("stall_dat", out_dat, pd);
               check("stall_idx", 32'(out_idx), 32'(pi));
               check("stall_last", {31'd0, out_last}, {31'd0, pl});
            end
            if (out_valid && out_ready) begin
               check("beat_expected", {31'd0, sb.size() > 0}, 32'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("beat_dat", out_dat, e.dat);
                  check("beat_idx", 32'(out_idx), 32'(e.idx));
                  check("beat_last", {31'd0, out_last}, {31'd0, e.last});
               end
            end
            pv = out_valid; pr = out_ready; pd = out_dat; pi = out_idx; pl = out_last;
         end
      end
   end

   initial begin
      int n;
      n_chk = 0;
      n_fail = 0;
      ready_mode = 0;
`ifdef SYS_ARR_DRAIN_NAN_CHECK_EN
      exp_nan = 1'b1;
`else
      exp_nan = 1'b0;
`endif
      nrst = 1'b0;
      comp_done = 1'b0;
      error = 1'b0;
      res_in = '0;
      repeat (3) tick();

      // Reset state
      check("rst_dat", out_dat, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_last", {31'd0, out_last}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, drain_done}, 32'd0);
      check("rst_err", {31'd0, err_flag}, 32'd0);
      check("rst_ovr", {31'd0, overrun}, 32'd0);
      check("rst_nan", {31'd0, nan_flag}, 32'd0);
      nrst = 1'b1;
      repeat (2) tick();

      // Basic drain with latency checks
      load({32'h40800000, 32'h40A00000, 32'h40000000, 32'h40400000});
      comp_done = 1'b1;
      tick();
      comp_done = 1'b0;
      @(negedge clk);
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_idx0", 32'(out_idx), 32'd0);
      check("t1_busy", {31'd0, busy}, 32'd1);
      n = 0;
      while (!drain_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t1_latency", 32'(n), 32'(N));
      @(negedge clk);
      check("t1_pulse", {31'd0, drain_done}, 32'd0);
      check("t1_idle_valid", {31'd0, out_valid}, 32'd0);
      check("t1_idle_busy", {31'd0, busy}, 32'd0);
      #1 check("t1_sb_empty", 32'(sb.size()), 32'd0);

      // Backpressure
      tick();
      ready_mode = 1;
      load({32'h40800000, 32'h40A00000, 32'h40000000, 32'h40400000});
      comp_done = 1'b1;
      tick();
      comp_done = 1'b0;
      wait_done(60, n);
      #1 check("t2_sb_empty", 32'(sb.size()), 32'd0);
      ready_mode = 0;
      repeat (2) tick();

      // Overrun: second rise during the drain
      check("t3_ovr_before", {31'd0, overrun}, 32'd0);
      load({32'h3F800000, 32'hBF800000, 32'h41200000, 32'h00000000});
      comp_done = 1'b1;
      tick();
      comp_done = 1'b0;
      tick();
      tick();
      comp_done = 1'b1;
      wait_done(20, n);
      check("t3_ovr_after", {31'd0, overrun}, 32'd1);
      comp_done = 1'b0;
      repeat (3) tick();
      #1 check("t3_sb_empty", 32'(sb.size()), 32'd0);

      // Held comp_done: single drain until 1->0->1
      load({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
      comp_done = 1'b1;
      tick();
      wait_done(20, n);
      repeat (10) @(negedge clk);
      check("t4_no_recap", {31'd0, busy}, 32'd0);
      #1 check("t4_sb_empty", 32'(sb.size()), 32'd0);
      check("t4_ovr_sticky", {31'd0, overrun}, 32'd1);
      tick();
      comp_done = 1'b0;
      tick();
      load({32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888});
      comp_done = 1'b1;
      tick();
      wait_done(20, n);
      comp_done = 1'b0;
      repeat (2) tick();
      #1 check("t4_sb_empty2", 32'(sb.size()), 32'd0);

      // Reset mid-drain at beat 1
      load({32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000});
      comp_done = 1'b1;
      tick();
      comp_done = 1'b0;
      tick();
      check("t5_beat1_idx", 32'(out_idx), 32'd1);
      #1 nrst = 1'b0;
      #1;
      check("t5_async_valid", {31'd0, out_valid}, 32'd0);
      check("t5_async_busy", {31'd0, busy}, 32'd0);
      check("t5_async_idx", 32'(out_idx), 32'd0);
      check("t5_async_dat", out_dat, 32'd0);
      check("t5_async_ovr", {31'd0, overrun}, 32'd0);
      sb.delete();
      repeat (2) tick();
      nrst = 1'b1;
      repeat (5) @(negedge clk);
      check("t5_stay_idle", {31'd0, busy}, 32'd0);
      check("t5_stay_valid", {31'd0, out_valid}, 32'd0);
      tick();

      // Error and NaN capture, then clean capture clears both
      error = 1'b1;
      load({32'h40800000, 32'h40A00000, 32'h7FC00000, 32'h40400000});
      comp_done = 1'b1;
      tick();
      comp_done = 1'b0;
      error = 1'b0;
      @(negedge clk);
      check("t6_err_set", {31'd0, err_flag}, 32'd1);
      check("t6_nan_set", {31'd0, nan_flag}, {31'd0, exp_nan});
      wait_done(20, n);
      check("t6_err_held", {31'd0, err_flag}, 32'd1);
      repeat (2) tick();
      load({32'h40800000, 32'h40A00000, 32'h40000000, 32'h40400000});
      comp_done = 1'b1;
      tick();
      comp_done = 1'b0;
      @(negedge clk);
      check("t6_err_clr", {31'd0, err_flag}, 32'd0);
      check("t6_nan_clr", {31'd0, nan_flag}, 32'd0);
      wait_done(20, n);
      repeat (2) tick();
      #1 check("t6_sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
